// File: rtl/mult_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arb_pkg
//  Description : Shared definitions for the shared-multiplier arbiter:
//                default sizing, requester tag width helper and the tag
//                record that travels alongside each multiplier operation.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    localparam int c_def_n_req      = 4;
    localparam int c_def_data_width = 32;
    localparam int c_def_mul_lat    = 1;

    // Tags are sized for the largest supported requester count (16) so one
    // struct type serves every instance; unused upper id bits stay zero.
    localparam int c_tag_id_w = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [c_tag_id_w-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/mult_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_arbiter_if
//  Description : Bundle of the requester-side valid/ready request and
//                response buses plus the multiplier operand/result lines.
//                master : requesters and the external multiplier
//                slave  : the arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_share_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int N_REQ      = c_def_n_req,
    parameter int DATA_WIDTH = c_def_data_width
) ();

    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ*DATA_WIDTH-1:0]   req_a;
    logic [N_REQ*DATA_WIDTH-1:0]   req_b;
    logic [N_REQ-1:0]              rsp_valid;
    logic [N_REQ-1:0]              rsp_ready;
    logic [N_REQ*2*DATA_WIDTH-1:0] rsp_data;
    logic                          mul_en;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;
    logic [2*DATA_WIDTH-1:0]       mul_result;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_result,
        input  req_ready, rsp_valid, rsp_data, mul_en, mul_a, mul_b
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_result,
        output req_ready, rsp_valid, rsp_data, mul_en, mul_a, mul_b
    );

endinterface
`default_nettype wire

// File: rtl/mult_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Scans elig starting at
//                ptr, wrapping modulo N, and grants the first hit.
//  Ports       : elig      - eligible requesters
//                ptr       - index with highest priority this cycle
//                grant     - one-hot grant (all zero when nothing eligible)
//                grant_id  - index of the granted requester
//                any_grant - a grant is active
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N    = c_def_n_req,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    elig,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any_grant
);

    always_comb begin
        int w_idx;
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!any_grant && elig[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_id     = ID_W'(w_idx);
                any_grant    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_arbiter
//  Description : Shares one pipelined multiplier among N_REQ requesters.
//                Round-robin grants one operand pair per cycle, tags it with
//                the requester id through a latency-matched pipe and returns
//                the full-width product on a registered per-requester
//                valid/ready response port.
//  Ports       : clk  - clock
//                rstn - asynchronous active-low reset
//                bus  - request/response buses and multiplier interface
//                idle - no requester has an operation outstanding
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ      = c_def_n_req,
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int MUL_LAT    = c_def_mul_lat
) (
    input  logic                clk,
    input  logic                rstn,
    mult_share_arbiter_if.slave bus,
    output logic                idle
);

    localparam int c_id_w = id_width(N_REQ);
    localparam int c_pw   = 2 * DATA_WIDTH;

    logic [c_id_w-1:0]       r_ptr;
    logic [N_REQ-1:0]        r_busy;
    tag_t                    r_tag [MUL_LAT];
    logic [N_REQ-1:0]        r_rsp_valid;
    logic [N_REQ*c_pw-1:0]   r_rsp_data;

    logic [N_REQ-1:0]        w_elig;
    logic [N_REQ-1:0]        w_grant;
    logic [c_id_w-1:0]       w_grant_id;
    logic                    w_any_grant;
    logic                    w_tag_live;
    logic [N_REQ-1:0]        w_cap;
    logic [N_REQ-1:0]        w_rsp_hs;

    // Busy gating limits each requester to one outstanding op, which is what
    // guarantees a free response slot without any pipe backpressure. Holding
    // eligibility low during reset keeps grants and mul_en quiet while rstn
    // is asserted.
    assign w_elig   = bus.req_valid & ~r_busy & {N_REQ{rstn}};
    assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (c_id_w)
    ) u_rr_arbiter (
        .elig      (w_elig),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_id  (w_grant_id),
        .any_grant (w_any_grant)
    );

    assign bus.req_ready = w_grant;

    always_comb begin
        bus.mul_a = '0;
        bus.mul_b = '0;
        if (w_any_grant) begin
            bus.mul_a = bus.req_a[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
            bus.mul_b = bus.req_b[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Last tag stage lines up with the product at mul_result; decode it to
    // a per-requester capture strobe.
    always_comb begin
        w_tag_live = 1'b0;
        w_cap      = '0;
        for (int s = 0; s < MUL_LAT; s++) begin
            w_tag_live = w_tag_live | r_tag[s].valid;
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (r_tag[MUL_LAT-1].valid && (r_tag[MUL_LAT-1].id == c_tag_id_w'(k))) begin
                w_cap[k] = 1'b1;
            end
        end
    end

    // The multiplier clears its register when disabled, so it is kept
    // enabled for as long as any tagged product is still travelling.
    assign bus.mul_en = w_any_grant | w_tag_live;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr  <= '0;
            r_busy <= '0;
        end else begin
            if (w_any_grant) begin
                r_ptr <= (int'(w_grant_id) == N_REQ - 1) ? '0 : w_grant_id + 1'b1;
            end
            r_busy <= (r_busy | w_grant) & ~w_rsp_hs;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0].valid <= w_any_grant;
            r_tag[0].id    <= c_tag_id_w'(w_grant_id);
            for (int s = 1; s < MUL_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (w_cap[k]) begin
                    r_rsp_valid[k]               <= 1'b1;
                    r_rsp_data[k*c_pw +: c_pw]   <= bus.mul_result;
                end else if (w_rsp_hs[k]) begin
                    r_rsp_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign idle          = ~|r_busy;

endmodule
`default_nettype wire

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one pipelined Multiplier_2 instance among N_REQ requesters in the convolution accelerator, for example PE lanes that need an occasional full-width product.
- Accepts operand pairs over valid/ready, grants one requester per cycle using round-robin order, and drives the multiplier.
- Tags each operation with its requester ID through a latency-matched pipe and returns the 2*DATA_WIDTH product to the originating requester over a registered valid/ready response port.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, operand width; must equal the multiplier's DATA_WIDTH.
- MUL_LAT, 1, cycles from operand issue to product valid at mul_result (1 for Multiplier_2).
- ID_W, $clog2(N_REQ), requester tag width (derived localparam).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active-low
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester accept (grant)
- req_a  in  N_REQ*DATA_WIDTH  packed operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  N_REQ*DATA_WIDTH  packed operand B
- rsp_valid  out  N_REQ  product available
- rsp_ready  in  N_REQ  requester consumes product
- rsp_data  out  N_REQ*2*DATA_WIDTH  packed products
- mul_en  out  1  to multiplier en
- mul_a  out  DATA_WIDTH  to multiplier a
- mul_b  out  DATA_WIDTH  to multiplier b
- mul_result  in  2*DATA_WIDTH  from multiplier result
- idle  out  1  no operation in flight and no rsp_valid pending

Behaviour:
- Reset values, async on rstn low:
  - rr pointer = 0
  - tag pipe valid bits = 0
  - busy = 0
  - rsp_valid = 0
  - rsp_data = 0
  - mul_en = 0
- mul_a and mul_b are 0 whenever no grant is active.
- Reset mid-operation discards all in-flight products; no rsp_valid appears after reset release until a new issue completes.
- Each requester has at most one outstanding operation. busy[i] sets on the grant and clears on the rsp handshake (rsp_valid[i] & rsp_ready[i]).
- Eligibility: elig[i] = req_valid[i] & ~busy[i].
- Arbitration (combinational): scan elig starting at index ptr, wrapping modulo N_REQ; the first hit is granted. At most one req_ready bit is high per cycle.
  - req_ready[i] = grant[i]. req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
  - On a grant to i, ptr <= (i+1) mod N_REQ. With no grant, ptr holds.
- Issue in cycle t when a grant is active:
  - mul_a/mul_b = req_a/req_b of the granted requester.
  - Tag pipe stage 0 <= {valid=1, id=i}.
- Tag pipe: MUL_LAT stages that shift every cycle, with no stall. Backpressure is unnecessary because the busy gating guarantees a free response slot.
- Capture:
  - When the last tag stage is valid with id k, rsp_data[k] <= mul_result and rsp_valid[k] <= 1 at the end of cycle t+MUL_LAT.
  - rsp_valid[k] is therefore first visible in cycle t+MUL_LAT+1.
- rsp_valid[k] clears on the rsp handshake. rsp_data[k] holds its value until the next capture.
- Back-to-back: if rsp_ready[k] is high in the first cycle rsp_valid[k] is high, requester k may be granted again the following cycle. Minimum per-requester interval is MUL_LAT+2 cycles. Aggregate throughput is one product per cycle when ≥ MUL_LAT+2 requesters are active.
- mul_en is high in any cycle with an active grant or any valid tag stage, and low otherwise.
  - Products are sampled only on tagged cycles, so the multiplier's register clear while en is low is harmless.
- idle = ~|busy.
- Simultaneous events:
  - A capture for k and an rsp handshake for k cannot coincide, because busy prevents a second issue.
  - A grant to i and a capture for a different j in the same cycle are independent.
  - req_valid dropping without ready is legal; nothing is issued.
- Arithmetic: full-width unsigned product from the multiplier. No truncation, rounding or overflow handling in this block.

Decomposition:
- Package mult_arb_pkg holds:
  - default N_REQ, DATA_WIDTH and MUL_LAT
  - ID_W derivation function
  - tag struct {valid, id}
- Sub-module rr_arbiter(N): inputs elig and ptr, outputs a one-hot grant, grant_id and any_grant. Purely combinational, reused elsewhere in the accelerator.
- The top module owns ptr, busy, the tag pipe, the response registers and the multiplier interface. The Multiplier_2 instance lives outside; the integration wrapper connects it.

Test Plan:
- Single op: reset, requester 2 sends a=7, b=6 at cycle 0 with rsp_ready=1 → req_ready[2]=1 at cycle 0, rsp_valid[2]=1 at cycle 2 with rsp_data[2]=42, idle=1 at cycle 3.
- Fairness: all 4 requesters hold req_valid with rsp_ready=1 and ptr=0 → grants go to 0,1,2,3,0,1,... one per cycle, with no requester granted twice within any 4 consecutive grants.
- Backpressure: requester 1 issues 0xFFFFFFFF×0xFFFFFFFF, keeps rsp_ready=0 for 10 cycles and keeps req_valid high → no further grant to 1, rsp_data[1]=0xFFFFFFFE00000001 stays stable, and a grant to 1 occurs the cycle after the rsp handshake.
- Width edge: a=0x80000000, b=2 → rsp_data=0x0000000100000000; a=0, b=0xDEADBEEF → 0.
- Reset mid-flight: issue from requesters 0 and 3, then assert rstn low in cycle 1 → all rsp_valid=0, busy=0, ptr=0 and mul_en=0; after release, no spurious rsp_valid.
- Parameter sweep with N_REQ=3 and MUL_LAT=3 against a behavioural multiplier model → every product is routed to the correct requester, and mul_en is low only when no grant is active and no tag stage is valid.
